// File: rtl/exu_trap_ctrl_pkg.sv
`default_nettype none
// exu_trap_ctrl_pkg -- cause codes, FSM encoding and interrupt slot mapping (rev 1.0)
package exu_trap_ctrl_pkg;

  localparam int CAUSE_W = 5;

  localparam logic [CAUSE_W-1:0] CAUSE_ILG     = 5'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_EBRK    = 5'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M = 5'd11;
  localparam logic [CAUSE_W-1:0] IRQ_MSI       = 5'd3;
  localparam logic [CAUSE_W-1:0] IRQ_MTI       = 5'd7;
  localparam logic [CAUSE_W-1:0] IRQ_MEI       = 5'd11;
  localparam logic [CAUSE_W-1:0] IRQ_LCL_BASE  = 5'd16;

  // Number of fixed-priority slots ahead of the local lines (MEI, MSI, MTI).
  localparam int N_STD_IRQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } kind_e;

  // Slot order is priority order: 0=MEI, 1=MSI, 2=MTI, 3+k=lcl[k].
  function automatic logic [CAUSE_W-1:0] irq_slot_cause(input logic [CAUSE_W-1:0] slot);
    logic [CAUSE_W-1:0] c;
    case (slot)
      5'd0:    c = IRQ_MEI;
      5'd1:    c = IRQ_MSI;
      5'd2:    c = IRQ_MTI;
      default: c = IRQ_LCL_BASE + slot - 5'd3;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exu_irq_prio.sv
`default_nettype none
// exu_irq_prio -- fixed-priority encoder, lowest set index wins (rev 1.0)
module exu_irq_prio #(
  parameter int N  = 7,
  parameter int IW = 5
) (
  input  logic [N-1:0]  pend_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_i[i]) begin
        idx_o = IW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exu_trap_ctrl.sv
`default_nettype none
// exu_trap_ctrl -- machine-mode trap/mret controller for the execute stage (rev 1.0)
module exu_trap_ctrl
  import exu_trap_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int N_LCL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_ex_vld,
  output logic             hs_ex_rdy,
  input  logic [XLEN-1:0]  i_ex_pc,
  input  logic [31:0]      i_ex_inst,
  input  logic [1:0]       i_ecabr,
  input  logic             i_ilg,
  input  logic             i_mret,
  input  logic             i_irq_mei,
  input  logic             i_irq_msi,
  input  logic             i_irq_mti,
  input  logic [N_LCL-1:0] i_irq_lcl,
  input  logic             i_mstatus_mie,
  input  logic [XLEN-1:0]  i_mie,
  input  logic             i_flush_ack,
  output logic             o_flush_req,
  output logic             o_trap_vld,
  output logic             o_mret_vld,
  output logic [XLEN-1:0]  o_mcause,
  output logic [XLEN-1:0]  o_mepc,
  output logic [XLEN-1:0]  o_mtval,
  output logic [XLEN-1:0]  o_mip
);

  localparam int NSLOT = N_STD_IRQ + N_LCL;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [XLEN-1:0]   mip_q, mip_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mtval_q, mtval_d;

  logic [XLEN-1:0]    w_masked;
  logic [NSLOT-1:0]   w_slots;
  logic [CAUSE_W-1:0] w_slot_idx;
  logic               w_slot_vld;
  logic [CAUSE_W-1:0] w_irq_cause;
  logic [CAUSE_W-1:0] w_exc_cause;
  logic               w_irq_take;
  logic               w_is_ilg;
  logic               w_trap_cond;
  logic               w_idle;
  logic               w_mret_acc;

  always_comb begin
    mip_d                          = '0;
    mip_d[IRQ_MEI]                 = i_irq_mei;
    mip_d[IRQ_MSI]                 = i_irq_msi;
    mip_d[IRQ_MTI]                 = i_irq_mti;
    mip_d[IRQ_LCL_BASE +: N_LCL]   = i_irq_lcl;
  end

  assign w_masked = mip_q & i_mie;
  assign w_slots  = {w_masked[IRQ_LCL_BASE +: N_LCL], w_masked[IRQ_MTI],
                     w_masked[IRQ_MSI], w_masked[IRQ_MEI]};

  exu_irq_prio #(
    .N  (NSLOT),
    .IW (CAUSE_W)
  ) u_prio (
    .pend_i (w_slots),
    .idx_o  (w_slot_idx),
    .vld_o  (w_slot_vld)
  );

  assign w_irq_cause = w_slot_vld ? irq_slot_cause(w_slot_idx) : '0;
  assign w_irq_take  = i_mstatus_mie & (|w_masked);

  // ecall and ebreak together is an encoding error, reported as illegal.
  assign w_is_ilg    = i_ilg | (i_ecabr == 2'b11);
  assign w_exc_cause = w_is_ilg   ? CAUSE_ILG :
                       i_ecabr[1] ? CAUSE_ECALL_M : CAUSE_EBRK;

  assign w_idle      = (state_q == ST_IDLE);
  assign w_trap_cond = hs_ex_vld & (w_irq_take | i_ilg | (|i_ecabr));
  assign hs_ex_rdy   = rst_n & w_idle & ~w_trap_cond;
  assign w_mret_acc  = w_idle & hs_ex_vld & i_mret & ~w_trap_cond;

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    mcause_d = mcause_q;
    mepc_d   = mepc_q;
    mtval_d  = mtval_q;
    case (state_q)
      ST_IDLE: begin
        if (w_trap_cond) begin
          kind_d  = KIND_TRAP;
          state_d = ST_FLUSH;
          mepc_d  = i_ex_pc;
          if (w_irq_take) begin
            mcause_d = {1'b1, (XLEN-1)'(w_irq_cause)};
            mtval_d  = '0;
          end else begin
            mcause_d = {1'b0, (XLEN-1)'(w_exc_cause)};
            mtval_d  = w_is_ilg ? XLEN'(i_ex_inst) : '0;
          end
        end else if (w_mret_acc) begin
          kind_d  = KIND_MRET;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (i_flush_ack) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      kind_q   <= KIND_TRAP;
      mip_q    <= '0;
      mcause_q <= '0;
      mepc_q   <= '0;
      mtval_q  <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      mip_q    <= mip_d;
      mcause_q <= mcause_d;
      mepc_q   <= mepc_d;
      mtval_q  <= mtval_d;
    end
  end

  assign o_flush_req = (state_q == ST_FLUSH);
  assign o_trap_vld  = (state_q == ST_COMMIT) & (kind_q == KIND_TRAP);
  assign o_mret_vld  = (state_q == ST_COMMIT) & (kind_q == KIND_MRET);
  assign o_mcause    = mcause_q;
  assign o_mepc      = mepc_q;
  assign o_mtval     = mtval_q;
  assign o_mip       = mip_q;

endmodule
`default_nettype wire

// File: tb/tb_exu_trap_ctrl.sv
`default_nettype none
// tb_exu_trap_ctrl -- directed stimulus with a commit scoreboard (rev 1.0)
module tb_exu_trap_ctrl;

  localparam int XLEN  = 32;
  localparam int N_LCL = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             hs_ex_vld;
  logic             hs_ex_rdy;
  logic [XLEN-1:0]  i_ex_pc;
  logic [31:0]      i_ex_inst;
  logic [1:0]       i_ecabr;
  logic             i_ilg, i_mret;
  logic             i_irq_mei, i_irq_msi, i_irq_mti;
  logic [N_LCL-1:0] i_irq_lcl;
  logic             i_mstatus_mie;
  logic [XLEN-1:0]  i_mie;
  logic             i_flush_ack;
  logic             o_flush_req, o_trap_vld, o_mret_vld;
  logic [XLEN-1:0]  o_mcause, o_mepc, o_mtval, o_mip;

  typedef struct packed {
    logic        is_mret;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   errors    = 0;
  int   checks    = 0;
  int   n_pushed  = 0;
  int   n_commits = 0;

  exu_trap_ctrl #(.XLEN(XLEN), .N_LCL(N_LCL)) dut (
    .clk(clk), .rst_n(rst_n), .hs_ex_vld(hs_ex_vld), .hs_ex_rdy(hs_ex_rdy),
    .i_ex_pc(i_ex_pc), .i_ex_inst(i_ex_inst), .i_ecabr(i_ecabr), .i_ilg(i_ilg),
    .i_mret(i_mret), .i_irq_mei(i_irq_mei), .i_irq_msi(i_irq_msi),
    .i_irq_mti(i_irq_mti), .i_irq_lcl(i_irq_lcl), .i_mstatus_mie(i_mstatus_mie),
    .i_mie(i_mie), .i_flush_ack(i_flush_ack), .o_flush_req(o_flush_req),
    .o_trap_vld(o_trap_vld), .o_mret_vld(o_mret_vld), .o_mcause(o_mcause),
    .o_mepc(o_mepc), .o_mtval(o_mtval), .o_mip(o_mip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every commit pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (o_trap_vld || o_mret_vld)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got trap=%0b mret=%0b expected none",
                 o_trap_vld, o_mret_vld);
      end else begin
        e = sb_q.pop_front();
        n_commits++;
        chk("commit_trap_vld", {31'b0, o_trap_vld}, {31'b0, ~e.is_mret});
        chk("commit_mret_vld", {31'b0, o_mret_vld}, {31'b0, e.is_mret});
        chk("commit_mcause", o_mcause, e.cause);
        chk("commit_mepc", o_mepc, e.epc);
        chk("commit_mtval", o_mtval, e.tval);
      end
    end
  end

  task automatic run_instr(input logic [31:0] pc, input logic [31:0] inst,
                           input logic ilg, input logic [1:0] ecabr, input logic mret,
                           input int ack_dly, input logic exp_commit, input logic exp_is_mret,
                           input logic [31:0] exp_cause, input logic [31:0] exp_epc,
                           input logic [31:0] exp_tval);
    hs_ex_vld = 1'b1;
    i_ex_pc   = pc;
    i_ex_inst = inst;
    i_ilg     = ilg;
    i_ecabr   = ecabr;
    i_mret    = mret;
    @(negedge clk);
    chk("ex_rdy", {31'b0, hs_ex_rdy}, (exp_commit && !exp_is_mret) ? 32'd0 : 32'd1);
    if (exp_commit) begin
      sb_q.push_back('{is_mret: exp_is_mret, cause: exp_cause, epc: exp_epc, tval: exp_tval});
      n_pushed++;
    end
    @(posedge clk); #1;
    hs_ex_vld = 1'b0;
    i_ilg     = 1'b0;
    i_ecabr   = 2'b00;
    i_mret    = 1'b0;
    if (exp_commit) begin
      for (int i = 1; i <= ack_dly; i++) begin
        i_flush_ack = (i == ack_dly);
        @(negedge clk);
        chk("flush_req_held", {31'b0, o_flush_req}, 32'd1);
        @(posedge clk); #1;
      end
      i_flush_ack = 1'b0;
      @(negedge clk);
      chk("commit_pulse", {31'b0, o_trap_vld | o_mret_vld}, 32'd1);
      chk("flush_req_drop", {31'b0, o_flush_req}, 32'd0);
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      chk("no_flush", {31'b0, o_flush_req}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; hs_ex_vld = 1'b0; i_ex_pc = '0; i_ex_inst = '0; i_ecabr = 2'b00;
    i_ilg = 1'b0; i_mret = 1'b0; i_irq_mei = 1'b0; i_irq_msi = 1'b0; i_irq_mti = 1'b0;
    i_irq_lcl = '0; i_mstatus_mie = 1'b0; i_mie = '0; i_flush_ack = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flush_req", {31'b0, o_flush_req}, 32'd0);
    chk("rst_trap_vld", {31'b0, o_trap_vld}, 32'd0);
    chk("rst_mret_vld", {31'b0, o_mret_vld}, 32'd0);
    chk("rst_rdy", {31'b0, hs_ex_rdy}, 32'd0);
    chk("rst_mcause", o_mcause, 32'd0);
    chk("rst_mepc", o_mepc, 32'd0);
    chk("rst_mtval", o_mtval, 32'd0);
    chk("rst_mip", o_mip, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exceptions: illegal with late ack, ecall/ebreak/both with varying ack.
    run_instr(32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 3, 1'b1, 1'b0,
              32'h0000_0002, 32'h8000_0010, 32'hFFFF_FFFF);
    run_instr(32'h0000_0100, 32'h0000_0073, 1'b0, 2'b10, 1'b0, 1, 1'b1, 1'b0,
              32'h0000_000B, 32'h0000_0100, 32'h0);
    run_instr(32'h0000_0104, 32'h0010_0073, 1'b0, 2'b01, 1'b0, 2, 1'b1, 1'b0,
              32'h0000_0003, 32'h0000_0104, 32'h0);
    run_instr(32'h0000_0108, 32'h1234_5678, 1'b0, 2'b11, 1'b0, 1, 1'b1, 1'b0,
              32'h0000_0002, 32'h0000_0108, 32'h1234_5678);

    // MTI and lcl[1] pending together.
    i_mie = 32'h0002_0080; i_mstatus_mie = 1'b1; i_irq_mti = 1'b1; i_irq_lcl = 4'b0010;
    @(posedge clk); #1;
    chk("mip_view", o_mip, 32'h0002_0080);
    run_instr(32'h0000_0200, 32'h0000_0013, 1'b0, 2'b00, 1'b0, 1, 1'b1, 1'b0,
              32'h8000_0007, 32'h0000_0200, 32'h0);
    i_mie = 32'h0002_0000;
    run_instr(32'h0000_0204, 32'h0000_0013, 1'b0, 2'b00, 1'b0, 2, 1'b1, 1'b0,
              32'h8000_0011, 32'h0000_0204, 32'h0);
    i_mstatus_mie = 1'b0;
    run_instr(32'h0000_0208, 32'h0000_0013, 1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0,
              32'h0, 32'h0, 32'h0);
    i_irq_mti = 1'b0; i_irq_lcl = '0;

    // MEI beats a simultaneous illegal instruction; mtval is zero.
    i_mie = 32'h0000_0800; i_mstatus_mie = 1'b1; i_irq_mei = 1'b1;
    @(posedge clk); #1;
    run_instr(32'h0000_0300, 32'hDEAD_BEEF, 1'b1, 2'b00, 1'b0, 1, 1'b1, 1'b0,
              32'h8000_000B, 32'h0000_0300, 32'h0);
    i_irq_mei = 1'b0;
    i_mie = 32'h0000_0008;
    @(posedge clk); #1;

    // mret with MSI rising alongside: pending only from FLUSH on.
    i_irq_msi = 1'b1;
    run_instr(32'h0000_0400, 32'h3020_0073, 1'b0, 2'b00, 1'b1, 2, 1'b1, 1'b1,
              32'h8000_000B, 32'h0000_0300, 32'h0);
    run_instr(32'h0000_0500, 32'h0000_0013, 1'b0, 2'b00, 1'b0, 1, 1'b1, 1'b0,
              32'h8000_0003, 32'h0000_0500, 32'h0);
    run_instr(32'h0000_0600, 32'h3020_0073, 1'b0, 2'b00, 1'b1, 1, 1'b1, 1'b0,
              32'h8000_0003, 32'h0000_0600, 32'h0);
    i_irq_msi = 1'b0; i_mstatus_mie = 1'b0;
    @(posedge clk); #1;

    // mret flagged illegal is an exception.
    run_instr(32'h0000_0700, 32'h3020_0073, 1'b1, 2'b00, 1'b1, 1, 1'b1, 1'b0,
              32'h0000_0002, 32'h0000_0700, 32'h3020_0073);

    // Reset during FLUSH aborts the trap.
    hs_ex_vld = 1'b1; i_ilg = 1'b1; i_ex_pc = 32'h0000_0800; i_ex_inst = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    hs_ex_vld = 1'b0; i_ilg = 1'b0;
    @(negedge clk);
    chk("pre_rst_flush_req", {31'b0, o_flush_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_flush_req", {31'b0, o_flush_req}, 32'd0);
    chk("abort_trap_vld", {31'b0, o_trap_vld}, 32'd0);
    chk("abort_rdy", {31'b0, hs_ex_rdy}, 32'd0);
    chk("abort_mcause", o_mcause, 32'd0);
    chk("abort_mepc", o_mepc, 32'd0);
    chk("abort_mtval", o_mtval, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_flush_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_trap_vld", {31'b0, o_trap_vld}, 32'd0);
      chk("post_rst_flush_req", {31'b0, o_flush_req}, 32'd0);
    end
    i_flush_ack = 1'b0;

    @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("commit_count", n_commits, n_pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
